// File: rtl/riscv_crypto_aes128_seq_if.sv
// riscv_crypto_aes128_seq_if: request, response and saes64 FU channels of the AES-128 sequencer.
// Ports: in_* request (valid/ready), out_* ciphertext (valid/ready), busy, fu_* operand issue / result.
// Modports: slave = sequencer side, master = requester + FU side.
interface riscv_crypto_aes128_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_pt;
    logic         in_reuse_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_ct;
    logic         busy;
    logic         fu_valid;
    logic [63:0]  fu_rs1;
    logic [63:0]  fu_rs2;
    logic [3:0]   fu_enc_rcon;
    logic         fu_op_ks1;
    logic         fu_op_ks2;
    logic         fu_op_encs;
    logic         fu_op_encsm;
    logic [63:0]  fu_rd;
    logic         fu_ready;

    modport slave (
        input  in_valid, in_key, in_pt, in_reuse_key, out_ready, fu_rd, fu_ready,
        output in_ready, out_valid, out_ct, busy,
        output fu_valid, fu_rs1, fu_rs2, fu_enc_rcon,
        output fu_op_ks1, fu_op_ks2, fu_op_encs, fu_op_encsm
    );

    modport master (
        output in_valid, in_key, in_pt, in_reuse_key, out_ready, fu_rd, fu_ready,
        input  in_ready, out_valid, out_ct, busy,
        input  fu_valid, fu_rs1, fu_rs2, fu_enc_rcon,
        input  fu_op_ks1, fu_op_ks2, fu_op_encs, fu_op_encsm
    );
endinterface

// File: rtl/riscv_crypto_aes128_seq.sv
// riscv_crypto_aes128_seq: runs one AES-128 block encryption as a sequence of saes64 FU ops.
// Latency: out_valid 51 cycles after accept (21 on a round-key cache hit), +1 per fu_ready=0 cycle.
// Backpressure: ciphertext held in DONE until out_ready; in_ready only in IDLE; FU stalls hold operands.
// Ports: g_clk, g_reset (synchronous, active high), bus (slave modport of riscv_crypto_aes128_seq_if).
// Option: define RISCV_CRYPTO_AES128_SEQ_RKCACHE_EN for an 11-entry round-key cache used by in_reuse_key.
module riscv_crypto_aes128_seq #(
    parameter int NR = 10   // AES-128 only
) (
    input logic                      g_clk,
    input logic                      g_reset,
    riscv_crypto_aes128_seq_if.slave bus
);
    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [2:0] {S_IDLE, S_KS1, S_KS2A, S_KS2B, S_ENC0, S_ENC1, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_s0, r_s1, r_k0, r_k1, r_t, r_n0;
    logic [3:0]  r_rnd;
    logic        r_hit;       // current request skips the key schedule

    logic          w_accept;
    logic          w_hit_acc;
    logic [127:0]  w_key_acc; // key xored into the plaintext at accept
    logic [127:0]  w_k_acc;   // round key loaded into k at accept
    logic [127:0]  w_rk_next; // cached round key rnd+1

    logic          w_fu_valid, w_ks1, w_ks2, w_encs, w_encsm;
    logic [63:0]   w_rs1, w_rs2;
    logic [3:0]    w_rcon;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

`ifdef RISCV_CRYPTO_AES128_SEQ_RKCACHE_EN
    logic [127:0] r_rk [0:NR];
    logic         r_cache_vld;

    assign w_hit_acc = bus.in_reuse_key && r_cache_vld;
    assign w_key_acc = w_hit_acc ? r_rk[0] : bus.in_key;
    assign w_k_acc   = w_hit_acc ? r_rk[1] : bus.in_key;
    assign w_rk_next = r_rk[r_rnd + 4'd1];

    // A new full run overwrites the store, so the old contents stop being usable at its accept.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_cache_vld <= 1'b0;
        end else if (w_accept && !w_hit_acc) begin
            r_cache_vld <= 1'b0;
        end else if (r_state == S_ENC1 && bus.fu_ready && r_rnd == LP_NR && !r_hit) begin
            r_cache_vld <= 1'b1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_reset) begin
            if (w_accept && !w_hit_acc) begin
                r_rk[0] <= bus.in_key;
            end
            if (r_state == S_KS2B && bus.fu_ready) begin
                r_rk[r_rnd] <= {bus.fu_rd, r_k0};
            end
        end
    end
`else
    logic w_unused_reuse;
    assign w_unused_reuse = bus.in_reuse_key;
    assign w_hit_acc      = 1'b0;
    assign w_key_acc      = bus.in_key;
    assign w_k_acc        = bus.in_key;
    assign w_rk_next      = {r_k1, r_k0};
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus FU issue decode; everything here depends on registered state only,
    // except the advance conditions, so fu_* never see in_* or out_ready combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_fu_valid  = 1'b0;
        w_ks1       = 1'b0;
        w_ks2       = 1'b0;
        w_encs      = 1'b0;
        w_encsm     = 1'b0;
        w_rs1       = '0;
        w_rs2       = '0;
        w_rcon      = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) w_state_nxt = w_hit_acc ? S_ENC0 : S_KS1;
            end
            S_KS1: begin
                w_fu_valid = 1'b1;
                w_ks1      = 1'b1;
                w_rs1      = r_k1;
                w_rcon     = r_rnd - 4'd1;
                if (bus.fu_ready) w_state_nxt = S_KS2A;
            end
            S_KS2A: begin
                w_fu_valid = 1'b1;
                w_ks2      = 1'b1;
                w_rs1      = r_t;
                w_rs2      = r_k0;
                if (bus.fu_ready) w_state_nxt = S_KS2B;
            end
            S_KS2B: begin
                w_fu_valid = 1'b1;
                w_ks2      = 1'b1;
                w_rs1      = r_k0;
                w_rs2      = r_k1;
                if (bus.fu_ready) w_state_nxt = S_ENC0;
            end
            S_ENC0, S_ENC1: begin
                w_fu_valid = 1'b1;
                w_encsm    = (r_rnd != LP_NR);
                w_encs     = (r_rnd == LP_NR);
                w_rs1      = (r_state == S_ENC0) ? r_s0 : r_s1;
                w_rs2      = (r_state == S_ENC0) ? r_s1 : r_s0;
                if (bus.fu_ready) begin
                    if (r_state == S_ENC0)     w_state_nxt = S_ENC1;
                    else if (r_rnd == LP_NR)   w_state_nxt = S_DONE;
                    else                       w_state_nxt = r_hit ? S_ENC0 : S_KS1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_s0  <= '0;
            r_s1  <= '0;
            r_k0  <= '0;
            r_k1  <= '0;
            r_t   <= '0;
            r_n0  <= '0;
            r_rnd <= '0;
            r_hit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_s0  <= bus.in_pt[63:0]   ^ w_key_acc[63:0];
                    r_s1  <= bus.in_pt[127:64] ^ w_key_acc[127:64];
                    r_k0  <= w_k_acc[63:0];
                    r_k1  <= w_k_acc[127:64];
                    r_rnd <= 4'd1;
                    r_hit <= w_hit_acc;
                end
                S_KS1:  if (bus.fu_ready) r_t  <= bus.fu_rd;
                S_KS2A: if (bus.fu_ready) r_k0 <= bus.fu_rd;
                S_KS2B: if (bus.fu_ready) r_k1 <= bus.fu_rd;
                S_ENC0: if (bus.fu_ready) r_n0 <= bus.fu_rd;
                S_ENC1: if (bus.fu_ready) begin
                    r_s0 <= r_n0 ^ r_k0;
                    r_s1 <= bus.fu_rd ^ r_k1;
                    if (r_rnd != LP_NR) begin
                        r_rnd <= r_rnd + 4'd1;
                        if (r_hit) {r_k1, r_k0} <= w_rk_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.out_ct      = {r_s1, r_s0};
    assign bus.fu_valid    = w_fu_valid;
    assign bus.fu_rs1      = w_rs1;
    assign bus.fu_rs2      = w_rs2;
    assign bus.fu_enc_rcon = w_rcon;
    assign bus.fu_op_ks1   = w_ks1;
    assign bus.fu_op_ks2   = w_ks2;
    assign bus.fu_op_encs  = w_encs;
    assign bus.fu_op_encsm = w_encsm;
endmodule

// File: doc/riscv_crypto_aes128_seq.md
# riscv_crypto_aes128_seq

Multi-cycle sequencer that performs one complete AES-128 block encryption by issuing saes64 operations (ks1, ks2, encsm, encs) to a shared single-cycle saes64 functional unit. Round keys are generated on the fly from the 128-bit cipher key. The block sits beside the saes64 unit as an autonomous accelerator front end. It owns the FU port bundle while busy and hands results back through a valid/ready output channel.

## Interface
- `NR`, 10: number of rounds; only 10 (AES-128) is legal.
- `g_clk` in 1: global clock.
- `g_reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: sequencer can accept a request.
- `in_key` in 128: cipher key.
- `in_pt` in 128: plaintext.
- `in_reuse_key` in 1: use cached round keys; ignored without the cache feature.
- `out_valid` out 1: ciphertext valid.
- `out_ready` in 1: consumer accepts ciphertext.
- `out_ct` out 128: ciphertext.
- `busy` out 1: a request is in flight.
- `fu_valid` out 1: FU operands valid.
- `fu_rs1` out 64: FU source 1.
- `fu_rs2` out 64: FU source 2.
- `fu_enc_rcon` out 4: FU ks1 round-number immediate.
- `fu_op_ks1`, `fu_op_ks2`, `fu_op_encs`, `fu_op_encsm` out 1 each: FU op selects, one-hot, all 0 when `fu_valid`=0.
- `fu_rd` in 64: FU result.
- `fu_ready` in 1: FU result valid this cycle.

## Operation
- Byte order: byte i of the AES block/key is at bits [8i+7:8i]. Low half is [63:0]; high half is [127:64].
- State registers:
  - s0/s1: state low/high.
  - k0/k1: key low/high.
  - t: ks1 temp.
  - rnd: 4-bit round counter, 1..10.
- FSM states: IDLE, KS1, KS2A, KS2B, ENC0, ENC1, DONE.
- IDLE: `in_ready`=1. On `in_valid`:
  - s = in_pt ^ in_key; k = in_key; rnd = 1.
  - Go to KS1, or to ENC0 on a cache hit (see Configuration).
- KS1: issue ks1, rs1=k1, rs2=0, rcon=rnd-1. t ← rd.
- KS2A: issue ks2, rs1=t, rs2=k0. k0 ← rd.
- KS2B: issue ks2, rs1=k0 (new value), rs2=k1. k1 ← rd.
- ENC0: issue rs1=s0, rs2=s1. Op is encsm if rnd<10, else encs. n0 ← rd.
- ENC1: issue rs1=s1, rs2=s0, same op. On completion:
  - s0 ← n0 ^ k0; s1 ← rd ^ k1.
  - If rnd=10, go to DONE.
  - Otherwise rnd+1, then KS1 (or ENC0 on a cache hit).
- State advance: each FU-issuing state holds `fu_valid`=1 with stable operands. It advances only in a cycle with `fu_ready`=1. If `fu_ready`=0, the state stalls with operands unchanged.
- DONE: `out_valid`=1, `out_ct`={s1,s0}, held stable until `out_ready`. Then go to IDLE.
- Back-to-back requests: `in_ready` is 1 only in IDLE. A new request is accepted no earlier than the cycle after the out handshake.
- Invalid `in_reuse_key`: if asserted while the cache is invalid, the request is treated as a full key-schedule run.
- Reset: `g_reset` in any state forces IDLE next cycle and discards the in-flight request.
  - Outputs after reset: all `fu_*` outputs 0, `out_valid`=0, `out_ct`=0, `busy`=0, `in_ready`=1.
  - The round-key cache is invalidated.

## Timing
- Accept occurs in the cycle `in_valid`&`in_ready`. `busy`=1 from the next cycle until the out handshake.
- With `fu_ready` always 1:
  - Full run: 10 rounds × 5 FU cycles. `out_valid` rises 51 cycles after accept.
  - Cache hit: 10 × 2 FU cycles. `out_valid` rises 21 cycles after accept.
- Each FU stall cycle adds exactly one cycle.
- `fu_*` outputs are registered-state decodes. There is no combinational path from `in_*` or `out_ready` to `fu_*`.
- `out_ct` and `out_valid` are registered.

## Configuration
- Macro: `RISCV_CRYPTO_AES128_SEQ_RKCACHE_EN`.
- Defined:
  - Adds an 11×128-bit round-key store and a cache-valid flag.
  - A full run writes round key r after KS2B of round r; round key 0 is written at accept.
  - The valid flag is set at DONE of a full run.
  - A request with `in_reuse_key`=1 and a valid cache skips KS1/KS2A/KS2B. k0/k1 are loaded from the store each round, and the initial xor uses stored key 0. `in_key` is ignored.
- Undefined:
  - No store is built; `in_reuse_key` is ignored.
  - Every request runs the full schedule with 51-cycle latency.

## Test plan
- FIPS-197 C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → `out_ct` 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` at accept+51.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
- C.1, then pt 3243f6a8885a308d313198a2e0370734 with `in_reuse_key`=1 and garbage `in_key` (RKCACHE_EN) → correct ct under key 000102…0f at accept+21. Without the macro, the ct uses the garbage key at accept+51.
- `fu_ready` randomly low 30% of cycles → the same C.1 ct. Operands are stable during every stall. Latency equals 51 plus the number of stall cycles.
- `out_ready` held low 10 cycles → `out_ct` and `out_valid` stable; `in_ready`=0 throughout; `in_valid` is ignored.
- `g_reset` at cycle 20 of a run → next cycle IDLE with all outputs at reset values. A subsequent `in_reuse_key`=1 request runs a full schedule.
